aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Sequential AES-128 key schedule generator. It accepts a 128-bit cipher key on a start pulse and emits round keys 0..10 one at a time under a valid/ready handshake. It sits directly upstream of the round-key addition stage, which consumes `round_key` one round at a time. Each next round key is computed on-the-fly from the current one, so no 11-entry key store is needed.

## Interface
- `word_size`, default 8: byte width; only 8 is supported.
- `array_size`, default 16: bytes per key; only 16 is supported.
- `clk`, in, 1: single clock, rising-edge.
- `rst`, in, 1: asynchronous, active-high reset. **One clock; reset is asynchronous and active-high.**
- `start`, in, 1: begin expansion of `key_in`.
- `key_in`, in, 128: cipher key in FIPS-197 order. `key_in[127:96]` is w0; byte k0 is `[127:120]`.
- `key_ready`, in, 1: the consumer accepts the current round key.
- `round_key`, out, 128: current round key, in the same byte order as `key_in`.
- `round`, out, 4: index of `round_key`, 0..10.
- `key_valid`, out, 1: `round_key` and `round` are valid.
- `busy`, out, 1: an expansion is in progress.
- `done`, out, 1: one-cycle pulse after round 10 is accepted.

## Operation
- States:
  - IDLE: `key_valid=0`, `busy=0`.
  - RUN: `key_valid=1`, `busy=1`.
  - Both `busy` and `key_valid` are registered.
- Transitions:
  - IDLE and `start`: load `round_key=key_in`, `round=0`, `rcon=8'h01`; go to RUN. `key_in` is sampled only on this edge.
  - RUN, handshake (`key_valid & key_ready`), `round<10`: `round_key` becomes the next key; `round+1`; `rcon=xtime(rcon)`, i.e. `{rcon[6:0],1'b0} ^ (rcon[7]?8'h1b:0)`.
  - RUN, handshake, `round==10`: go to IDLE; `done=1` for one cycle.
  - RUN with no handshake: all outputs hold stable.
- Next-key arithmetic, with words w0..w3 of the current key:
  - `t = SubWord(RotWord(w3)) ^ {rcon,24'h0}`
  - `w0'=w0^t`, `w1'=w1^w0'`, `w2'=w2^w1'`, `w3'=w3^w2'`
  - All of this is combinational from registered state; 4 S-box instances are internal.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- `start` while RUN: ignored unless `AES_KEY_RESTART_EN` is defined (see Configuration).
- `start` in the same cycle as the final handshake: the final handshake wins and the block goes to IDLE. This `start` is not retained; it must be re-asserted.
- Reset mid-operation: immediate return to IDLE. The partial schedule is discarded and there is no `done` pulse.

## Timing
- Reset values: `round_key=0`, `round=0`, `key_valid=0`, `busy=0`, `done=0`, internal `rcon=8'h01`, state IDLE.
- Latency from `start`:
  - `start` sampled at edge N gives `key_valid=1`, `round=0` after edge N.
  - Round k appears after edge N+k when `key_ready` is held high.
  - With `key_ready` held high, the 11 keys occupy 11 consecutive cycles.
  - `done` is asserted for the cycle after edge N+11, together with `key_valid=0`.
- Throughput: one round key per cycle. Backpressure stalls the schedule indefinitely with no loss.
- `key_ready` while `key_valid=0` has no effect.

## Configuration
- Macro `AES_KEY_RESTART_EN`:
  - Defined: `start` in RUN, with no final handshake in that cycle, reloads `key_in`, `round=0`, `rcon=01` at that edge. No `done` pulse is produced for the aborted schedule.
  - Undefined: `start` is ignored whenever the state is RUN.

## Test plan
- FIPS-197 vector: key `2b7e151628aed2a6abf7158809cf4f3c`, `key_ready=1`.
  - round 1 = `a0fafe1788542cb123a339392a6c7605`
  - round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - `done` one cycle after round 10.
- All-zero key:
  - round 0 = 0
  - round 1 = `62636363626363636263636362636363`
  - round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`
- Backpressure: with the FIPS key, drop `key_ready` for 3 cycles at round 4.
  - `round_key` and `round=4` hold for those cycles.
  - Round 5 = `d4d1c6f87c839d87caf2b8bc11f915bc` follows after `key_ready` returns.
- Start during RUN at round 3 with the zero key:
  - Macro undefined: the FIPS schedule continues unchanged.
  - Macro defined: the next cycle shows `round=0` with `round_key=0`.
- Reset mid-run: assert `rst` asynchronously at round 6.
  - All outputs go to 0 immediately, with no `done`.
  - A fresh `start` then reproduces round 1 = `a0fafe17...`.
- Final handshake coincident with `start`: the block goes to IDLE with `done=1`, and `key_valid=0` on the next cycle.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128 key schedule generator: emits round keys 0..10 under valid/ready, each derived on the fly from the previous one.
// Optional feature: define AES_KEY_RESTART_EN to let start reload the key while a schedule is running.
module aes_key_expand #(
  parameter int unsigned word_size  = 8,
  parameter int unsigned array_size = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [word_size*array_size-1:0]   key_in,
  input  logic                              key_ready,
  output logic [word_size*array_size-1:0]   round_key,
  output logic [3:0]                        round,
  output logic                              key_valid,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned KEY_W      = word_size * array_size;
  localparam logic [3:0]  LAST_ROUND = 4'd10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;

`ifdef AES_KEY_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q;
  logic [KEY_W-1:0]   key_q;
  logic [3:0]         round_q;
  logic [7:0]         rcon_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [31:0]        w0, w1, w2, w3;
  logic [31:0]        rot_w, sub_w, t_w;
  logic [31:0]        n0, n1, n2, n3;
  logic [KEY_W-1:0]   key_d;
  logic [7:0]         rcon_d;
  logic               hs;

  // Next round key, purely combinational from the registered key and rcon.
  assign {w0, w1, w2, w3} = key_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_w[8*i +: 8] = SBOX[rot_w[8*i +: 8]];
  end

  assign t_w    = sub_w ^ {rcon_q, 24'h000000};
  assign n0     = w0 ^ t_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign key_d  = {n0, n1, n2, n3};
  assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign hs     = valid_q & key_ready;

  // Schedule FSM; the final handshake takes priority over a coincident start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            key_q   <= key_in;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (hs && (round_q == LAST_ROUND)) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (RESTART_EN && start) begin
            key_q   <= key_in;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
          end else if (hs) begin
            key_q   <= key_d;
            round_q <= round_q + 4'd1;
            rcon_q  <= rcon_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign round_key = key_q;
  assign round     = round_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: reference schedule built from GF(2^8) field arithmetic and the FIPS-197 word recurrence.
module tb_aes_key_expand;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic          key_ready;
  logic [127:0]  round_key;
  logic [3:0]    round;
  logic          key_valid;
  logic          busy;
  logic          done;

  aes_key_expand #(.word_size(8), .array_size(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .round_key (round_key),
    .round     (round),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox_ref [256];
  logic [127:0] ref_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--)
      if (p[i]) p ^= 15'(9'h11b) << (i - 8);
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbox_ref[a] = s ^ 8'h63;
    end
  endtask

  task automatic compute_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp ^= {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_schedule(input logic [127:0] k);
    compute_ref(k);
    for (int r = 0; r < 11; r++) begin
      exp_t e;
      e.rnd = 4'(r);
      e.key = ref_keys[r];
      sb.push_back(e);
    end
  endtask

  // Called at posedge+2 with the DUT idle; returns at posedge+2 after start was sampled.
  task automatic start_key(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    push_schedule(k);
    @(posedge clk); #2;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(key_valid && round == r) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    n_tests++;
    if (!(key_valid && round == r)) begin
      n_fail++;
      $display("FAIL wait_round_%0d: timed out, round=%0d valid=%0b", r, round, key_valid);
    end
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      @(posedge clk); #2;
      if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    n_tests++;
    if (busy || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wait_idle: timed out, busy=%0b pending=%0d", busy, sb.size());
      sb.delete();
    end
    key_ready = 1'b1;
    @(posedge clk); #2;
  endtask

  // Monitor: compares presented keys with the scoreboard head and checks the done pulse.
  initial begin
    bit exp_done;
    exp_t e;
    exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        check("done_pulse", 128'(done), 128'(exp_done));
        exp_done = 1'b0;
        if (key_valid) begin
          check("busy_with_valid", 128'(busy), 128'(1'b1));
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_key: round=%0d key=%h with empty scoreboard", round, round_key);
          end else begin
            e = sb[0];
            check("sb_round", 128'(round), 128'(e.rnd));
            check("sb_key", round_key, e.key);
            if (key_ready) begin
              void'(sb.pop_front());
              if (e.rnd == 4'd10) exp_done = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
    build_sbox();
    repeat (2) @(posedge clk);
    #2;
    check("rst_round_key", round_key, 128'h0);
    check("rst_round", 128'(round), 128'h0);
    check("rst_valid", 128'(key_valid), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_done", 128'(done), 128'h0);
    rst = 1'b0;

    // key_ready toggling while idle must have no effect
    repeat (5) begin
      @(posedge clk); #2;
      key_ready = 1'($urandom_range(0, 1));
    end
    check("idle_valid", 128'(key_valid), 128'h0);

    // FIPS vector, cycle-exact latency with ready held high
    key_ready = 1'b1;
    start_key(FIPS_KEY);
    check("fips_r0_round", 128'(round), 128'h0);
    check("fips_r0_key", round_key, FIPS_KEY);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      check("fips_lat_round", 128'(round), 128'(k));
      if (k == 1)  check("fips_r1", round_key, FIPS_R1);
      if (k == 10) check("fips_r10", round_key, FIPS_R10);
    end
    @(posedge clk); #2;
    check("fips_done", 128'(done), 128'h1);
    check("fips_done_valid", 128'(key_valid), 128'h0);
    @(posedge clk); #2;
    check("fips_done_clear", 128'(done), 128'h0);
    wait_idle(1'b0);

    // All-zero key
    start_key(128'h0);
    check("zero_r0", round_key, 128'h0);
    @(posedge clk); #2;
    check("zero_r1", round_key, ZERO_R1);
    wait_round(4'd10);
    check("zero_r10", round_key, ZERO_R10);
    wait_idle(1'b0);

    // Backpressure at round 4
    start_key(FIPS_KEY);
    wait_round(4'd4);
    key_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      check("bp_hold_round", 128'(round), 128'd4);
      check("bp_hold_key", round_key, ref_keys[4]);
    end
    key_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_r5_round", 128'(round), 128'd5);
    check("bp_r5_key", round_key, FIPS_R5);
    wait_idle(1'b0);

    // Start with zero key during RUN at round 3
    start_key(FIPS_KEY);
    wait_round(4'd3);
    start  = 1'b1;
    key_in = 128'h0;
    @(posedge clk); #2;
    start  = 1'b0;
`ifdef AES_KEY_RESTART_EN
    check("restart_round", 128'(round), 128'h0);
    check("restart_key", round_key, 128'h0);
    sb.delete();
    push_schedule(128'h0);
`else
    check("norestart_round", 128'(round), 128'd4);
    check("norestart_key", round_key, ref_keys[4]);
`endif
    wait_idle(1'b0);

    // Asynchronous reset mid-run at round 6
    start_key(FIPS_KEY);
    wait_round(4'd6);
    #1;
    rst = 1'b1;
    #1;
    check("arst_round_key", round_key, 128'h0);
    check("arst_round", 128'(round), 128'h0);
    check("arst_valid", 128'(key_valid), 128'h0);
    check("arst_busy", 128'(busy), 128'h0);
    check("arst_done", 128'(done), 128'h0);
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    check("post_rst_done", 128'(done), 128'h0);
    start_key(FIPS_KEY);
    @(posedge clk); #2;
    check("post_rst_r1", round_key, FIPS_R1);
    wait_idle(1'b0);

    // Final handshake coincident with start
    start_key(FIPS_KEY);
    wait_round(4'd10);
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #2;
    start  = 1'b0;
    check("coinc_valid", 128'(key_valid), 128'h0);
    check("coinc_done", 128'(done), 128'h1);
    check("coinc_busy", 128'(busy), 128'h0);
    @(posedge clk); #2;
    check("coinc_not_retained", 128'(key_valid), 128'h0);
    wait_idle(1'b0);

    // Random keys with random backpressure
    for (int t = 0; t < 8; t++) begin
      key_ready = 1'($urandom_range(0, 1));
      start_key({$urandom, $urandom, $urandom, $urandom});
      wait_idle(1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 128'(sb.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
